// File: rtl/galois_bn254_pkg.sv
`default_nettype none
// ---- galois_bn254_pkg : BN254 scalar-field constants and element type ---- rev 1.0
package galois_bn254_pkg;

  localparam int N_BITS  = 254;
  localparam int R_BITS  = N_BITS + 2;
  localparam int LATENCY = 8;

  typedef logic [N_BITS-1:0] fe_t;

  localparam logic [R_BITS-1:0] P_EXT =
    256'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;
  localparam fe_t P = P_EXT[N_BITS-1:0];

  // Barrett constant floor(2^(2*N_BITS) / P), folded at elaboration time.
  localparam logic [2*R_BITS-1:0] MU_WIDE = (512'd1 << (2 * N_BITS)) / 512'(P_EXT);
  localparam logic [R_BITS-1:0]   MU      = MU_WIDE[R_BITS-1:0];

endpackage
`default_nettype wire

// File: rtl/galois_pipe_mult.sv
`default_nettype none
// ---- galois_pipe_mult : STAGES-deep multiplier, one multiplier slice accumulated per stage ---- rev 1.0
module galois_pipe_mult #(
  parameter int A_W    = 254,
  parameter int B_W    = 254,
  parameter int P_W    = 508,
  parameter int STAGES = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] p
);

  localparam int SW = (B_W + STAGES - 1) / STAGES;
  localparam int BP = SW * STAGES;

  // Each stage consumes the low slice of its (right-shifted) multiplier copy.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [A_W-1:0]       a_in;
    logic [BP-s*SW-1:0]   b_in;
    logic [P_W-1:0]       acc_in;
    logic [P_W-1:0]       term;
    logic [P_W-1:0]       acc_q;

    if (s == 0) begin : g_head
      assign a_in   = a;
      assign b_in   = BP'(b);
      assign acc_in = '0;
    end else begin : g_body
      assign a_in   = g_stage[s-1].g_fwd.a_q;
      assign b_in   = g_stage[s-1].g_fwd.b_q;
      assign acc_in = g_stage[s-1].acc_q;
    end

    assign term = (P_W'(a_in) * P_W'(b_in[SW-1:0])) << (s * SW);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_in + term;
    end

    if (s < STAGES - 1) begin : g_fwd
      logic [A_W-1:0]           a_q;
      logic [BP-(s+1)*SW-1:0]   b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_in;
          b_q <= b_in[BP-s*SW-1:SW];
        end
      end
    end
  end

  assign p = g_stage[STAGES-1].acc_q;

endmodule
`default_nettype wire

// File: rtl/galois_mult_barrett_sync.sv
`default_nettype none
// ---- galois_mult_barrett_sync : 8-cycle pipelined (num1*num2) mod P over BN254, Barrett reduction ---- rev 1.0
module galois_mult_barrett_sync
  import galois_bn254_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BITS-1:0] num1,
  input  logic [N_BITS-1:0] num2,
  output logic [N_BITS-1:0] product,
  output logic              ready
);

  localparam int QW = 2 * N_BITS + 1;
  localparam logic [R_BITS-1:0] P1 = R_BITS'(P);
  localparam logic [R_BITS-1:0] P2 = R_BITS'(P) << 1;

  logic [2*N_BITS-1:0] x;
  logic [QW-1:0]       qprod;
  fe_t                 q;
  logic [R_BITS-1:0]   qp;
  logic [R_BITS-1:0]   x_dly [4];
  logic [R_BITS-1:0]   r0, r1, r2, fix;
  logic [LATENCY-1:0]  fill;

  galois_pipe_mult #(.A_W(N_BITS), .B_W(N_BITS), .P_W(2*N_BITS), .STAGES(3)) u_x (
    .clk(clk), .rst_n(rst_n), .a(num1), .b(num2), .p(x)
  );

  galois_pipe_mult #(.A_W(N_BITS+1), .B_W(R_BITS), .P_W(QW), .STAGES(3)) u_q (
    .clk(clk), .rst_n(rst_n), .a(x[2*N_BITS-1:N_BITS-1]), .b(MU), .p(qprod)
  );

  assign q = fe_t'(qprod >> (N_BITS + 1));

  // Only the low R_BITS of Q*P matter: the remainder is known to be below 3P.
  galois_pipe_mult #(.A_W(N_BITS), .B_W(N_BITS), .P_W(R_BITS), .STAGES(1)) u_qp (
    .clk(clk), .rst_n(rst_n), .a(q), .b(P), .p(qp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) x_dly[i] <= '0;
    end else begin
      x_dly[0] <= x[R_BITS-1:0];
      for (int i = 1; i < 4; i++) x_dly[i] <= x_dly[i-1];
    end
  end

  always_comb begin
    r0  = x_dly[3] - qp;
    r1  = r0 - P1;
    r2  = r0 - P2;
    fix = r0;
    if (r0 >= P2)      fix = r2;
    else if (r0 >= P1) fix = r1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
      fill    <= '0;
    end else begin
      product <= fe_t'(fix);
      fill    <= {fill[LATENCY-2:0], 1'b1};
    end
  end

  assign ready = fill[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_galois_mult_barrett_sync.sv
`default_nettype none
// ---- tb_galois_mult_barrett_sync : directed and streamed checks of the BN254 modular multiplier ---- rev 1.0
module tb_galois_mult_barrett_sync;
  import galois_bn254_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  fe_t  num1 = '0;
  fe_t  num2 = '0;
  fe_t  product;
  logic ready;

  int n_tests = 0;
  int n_fail  = 0;

  fe_t   exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  galois_mult_barrett_sync dut (
    .clk(clk), .rst_n(rst_n), .num1(num1), .num2(num2), .product(product), .ready(ready)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic fe_t ref_mul(input fe_t a, input fe_t b);
    logic [511:0] w;
    w = 512'(a) * 512'(b);
    return fe_t'(w % 512'(P));
  endfunction

  function automatic fe_t rand_fe();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    v[255:254] = 2'b00;
    if (v >= 256'(P)) v = v - 256'(P);
    return fe_t'(v);
  endfunction

  // One clock: drive a pair, then score the pair that entered LATENCY-1 edges earlier.
  task automatic cycle(input fe_t a, input fe_t b, input fe_t e, input string tag);
    fe_t   ef;
    string tf;
    num1 = a;
    num2 = b;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    check({tag, "_ready"}, 256'(ready), 256'(exp_q.size() >= LATENCY));
    if (exp_q.size() >= LATENCY) begin
      ef = exp_q.pop_front();
      tf = tag_q.pop_front();
      check(tf, 256'(product), 256'(ef));
    end else begin
      check("fill_product", 256'(product), 256'd0);
    end
  endtask

  initial begin
    fe_t a, b, pm1, inv2;
    pm1  = P - 1;
    inv2 = fe_t'((256'(P) + 256'd1) >> 1);

    repeat (3) @(posedge clk);
    #1;
    check("reset_product", 256'(product), 256'd0);
    check("reset_ready", 256'(ready), 256'd0);
    rst_n = 1'b1;

    cycle(254'd2, 254'd3, 254'd6, "mul_2x3");

    a = rand_fe();
    b = rand_fe();
    cycle(a, b, ref_mul(a, b), "stream_ab");
    cycle(254'd1, b, b, "stream_1b");

    cycle(pm1, pm1, 254'd1, "pm1_sq");
    cycle(pm1, 254'd2, P - 2, "pm1_x2");
    cycle(254'd0, pm1, 254'd0, "zero_x");
    cycle(254'd1, pm1, pm1, "one_x");

    // X = k*P - j sits just below a multiple of P; X = P + 1 just above.
    cycle(pm1, 254'd3, P - 3, "below_3p");
    cycle(pm1, 254'd5, P - 5, "below_5p");
    cycle(pm1, 254'd7, P - 7, "below_7p");
    cycle(inv2, 254'd2, 254'd1, "above_p");
    cycle(pm1, inv2, P - inv2, "pm1_inv2");

    for (int i = 0; i < 10000; i++) begin
      a = rand_fe();
      b = rand_fe();
      cycle(a, b, ref_mul(a, b), "rand");
    end

    for (int i = 0; i < 4; i++) begin
      a = rand_fe();
      b = rand_fe();
      cycle(a, b, ref_mul(a, b), "pre_rst");
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_product", 256'(product), 256'd0);
    check("midrst_ready", 256'(ready), 256'd0);
    exp_q.delete();
    tag_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    cycle(254'd5, 254'd7, 254'd35, "post_rst");
    cycle(pm1, pm1, 254'd1, "post_pm1_sq");
    for (int i = 0; i < LATENCY; i++) cycle(254'd0, 254'd0, 254'd0, "flush");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
